// File: rtl/clock_mode_ctrl.sv
// Run/set-hour/set-minute controller for the HH:MM clock: seconds count, inc strobes, key auto-repeat, blink mask.
// Inputs are registered once, so strobes and state changes appear one cycle after the input is sampled; no backpressure.
module clock_mode_ctrl #(
    parameter int HOLD_CYCLES   = 5000000,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_key_mode,
    input  logic       i_key_inc,
    output logic       o_min_inc,
    output logic       o_min_carry_en,
    output logic       o_hr_inc,
    output logic [1:0] o_mode,
    output logic [3:0] o_blink_mask,
    output logic [5:0] o_sec
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_W   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REPEAT_W = CW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t          r_state;
    logic            r_tick;
    logic            r_mode_s, r_mode_d;
    logic            r_inc_s, r_inc_d;
    logic [1:0]      r_hist_vld;
    logic            r_rpt_act;
    logic            r_hold_done;
    logic [CW-1:0]   r_rpt_cnt;
    logic            r_phase;

    state_t          w_next_state;
    logic            w_mode_press;
    logic            w_inc_press;
    logic            w_set;
    logic            w_rpt_fire;
    logic            w_strobe;
    logic            w_next_phase;
    logic [3:0]      w_blink;

    // History is trusted only once two real samples exist, so keys held through reset never look like a press.
    assign w_mode_press = r_hist_vld[1] & r_mode_d & ~r_mode_s;
    assign w_inc_press  = r_hist_vld[1] & r_inc_d & ~r_inc_s;
    assign w_set        = (r_state != ST_RUN);
    assign w_rpt_fire   = r_rpt_act & ~r_inc_s &
                          (r_hold_done ? (r_rpt_cnt == REPEAT_W) : (r_rpt_cnt == HOLD_W));
    assign w_strobe     = w_set & ~w_mode_press & (w_inc_press | w_rpt_fire);
    assign w_next_phase = w_mode_press ? 1'b0 : ((w_set & r_tick) ? ~r_phase : r_phase);

    always_comb begin
        w_next_state = r_state;
        if (w_mode_press) begin
            case (r_state)
                ST_RUN:    w_next_state = ST_SET_HR;
                ST_SET_HR: w_next_state = ST_SET_MIN;
                default:   w_next_state = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_blink = 4'b0000;
        if (w_next_phase && r_inc_s) begin
            if (w_next_state == ST_SET_HR) begin
                w_blink = 4'b1100;
            end else if (w_next_state == ST_SET_MIN) begin
                w_blink = 4'b0011;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= ST_RUN;
            r_tick         <= 1'b0;
            r_mode_s       <= 1'b1;
            r_mode_d       <= 1'b1;
            r_inc_s        <= 1'b1;
            r_inc_d        <= 1'b1;
            r_hist_vld     <= 2'b00;
            r_rpt_act      <= 1'b0;
            r_hold_done    <= 1'b0;
            r_rpt_cnt      <= '0;
            r_phase        <= 1'b0;
            o_min_inc      <= 1'b0;
            o_min_carry_en <= 1'b0;
            o_hr_inc       <= 1'b0;
            o_mode         <= 2'b00;
            o_blink_mask   <= 4'b0000;
            o_sec          <= 6'd0;
        end else begin
            r_tick     <= i_tick;
            r_mode_s   <= i_key_mode;
            r_mode_d   <= r_mode_s;
            r_inc_s    <= i_key_inc;
            r_inc_d    <= r_inc_s;
            r_hist_vld <= {r_hist_vld[0], 1'b1};

            r_state      <= w_next_state;
            r_phase      <= w_next_phase;
            o_mode       <= w_next_state;
            o_blink_mask <= w_blink;

            o_min_inc      <= 1'b0;
            o_min_carry_en <= 1'b0;
            o_hr_inc       <= 1'b0;

            // A tick is judged under the pre-transition state, even alongside a mode press.
            if (r_state == ST_RUN && r_tick) begin
                if (o_sec == 6'd59) begin
                    o_sec          <= 6'd0;
                    o_min_inc      <= 1'b1;
                    o_min_carry_en <= 1'b1;
                end else begin
                    o_sec <= o_sec + 6'd1;
                end
            end
            if (r_state == ST_SET_MIN && w_mode_press) begin
                o_sec <= 6'd0;
            end

            if (w_strobe) begin
                if (r_state == ST_SET_HR) begin
                    o_hr_inc <= 1'b1;
                end else begin
                    o_min_inc <= 1'b1;
                end
            end

            // Counter restarts on every strobe, so it only ever counts up to the current target.
            if (w_mode_press || !w_set || r_inc_s) begin
                r_rpt_act   <= 1'b0;
                r_hold_done <= 1'b0;
                r_rpt_cnt   <= '0;
            end else if (w_inc_press) begin
                r_rpt_act   <= 1'b1;
                r_hold_done <= 1'b0;
                r_rpt_cnt   <= CW'(1);
            end else if (r_rpt_act) begin
                if (w_rpt_fire) begin
                    r_hold_done <= 1'b1;
                    r_rpt_cnt   <= CW'(1);
                end else if (r_rpt_cnt != '1) begin
                    r_rpt_cnt <= r_rpt_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: row table for mode/sec/blink, strobe scoreboard with exact cycle stamps.
module tb_clock_mode_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       min_inc, min_carry_en, hr_inc;
    logic [1:0] mode;
    logic [3:0] blink_mask;
    logic [5:0] sec;

    clock_mode_ctrl #(.HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_key_mode(key_mode), .i_key_inc(key_inc),
        .o_min_inc(min_inc), .o_min_carry_en(min_carry_en), .o_hr_inc(hr_inc),
        .o_mode(mode), .o_blink_mask(blink_mask), .o_sec(sec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t, km, ki;
        logic [1:0] mode;
        logic [5:0] sec;
        logic [3:0] blink;
        logic [2:0] strb;   // {min_inc, hr_inc, min_carry_en}
    } vec_t;

    typedef struct {
        int   cyc;
        logic hr;
        logic carry;
    } sb_t;

    vec_t vecs[21];
    sb_t  sb[$];
    sb_t  e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_strobe(input int at, input logic hr, input logic carry);
        sb_t s;
        s.cyc = at; s.hr = hr; s.carry = carry;
        sb.push_back(s);
    endtask

    function automatic int pack_outs();
        return int'({mode, sec, blink_mask, min_inc, hr_inc, min_carry_en});
    endfunction

    task automatic apply_row(input int i);
        vec_t v;
        v = vecs[i];
        tick = v.t; key_mode = v.km; key_inc = v.ki;
        if (v.strb != 3'b000) push_strobe(cyc + 2, v.strb[1], v.strb[0]);
        next_cycle();
        tick = 1'b0;
        next_cycle();
        chk($sformatf("row%0d", i), pack_outs(), int'({v.mode, v.sec, v.blink, v.strb}));
    endtask

    // Strobe monitor: every strobe must match the scoreboard head at its exact cycle.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL strobe_missing: got none by cycle %0d, want strobe at cycle %0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (min_inc || hr_inc) begin
                n_chk++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL strobe_unexpected: got min=%0b hr=%0b at cycle %0d, want none", min_inc, hr_inc, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({min_inc, hr_inc, min_carry_en} !== {~e.hr, e.hr, e.carry}) begin
                        n_err++;
                        $display("FAIL strobe_kind: got min/hr/carry=%b%b%b at cycle %0d, want %b%b%b",
                                 min_inc, hr_inc, min_carry_en, cyc, ~e.hr, e.hr, e.carry);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        //            t     km    ki    mode  sec    blink    strb
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd0, 6'd1, 4'b0000, 3'b000};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 6'd2, 4'b0000, 3'b000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 6'd2, 4'b0000, 3'b000};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 6'd2, 4'b1100, 3'b000};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 6'd2, 4'b0000, 3'b000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 6'd2, 4'b0000, 3'b010};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 6'd2, 4'b0000, 3'b000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd1, 6'd2, 4'b0000, 3'b000};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd2, 4'b1100, 3'b000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 6'd2, 4'b0000, 3'b000};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 2'd2, 6'd2, 4'b0011, 3'b000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd2, 6'd2, 4'b0000, 3'b100};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 2'd2, 6'd2, 4'b0011, 3'b000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 4'b0000, 3'b000};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 2'd1, 6'd0, 4'b0000, 3'b101};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd0, 4'b0000, 3'b000};

        // Reset with both keys held low.
        repeat (3) next_cycle();
        chk("reset_state", pack_outs(), 0);
        rst = 1'b1;

        for (int i = 0; i <= 3; i++) apply_row(i);

        // RUN: 60 ticks, rollover on the last one.
        for (int i = 1; i <= 60; i++) begin
            tick = 1'b1;
            if (i == 60) push_strobe(cyc + 2, 1'b0, 1'b1);
            next_cycle();
            tick = 1'b0;
            next_cycle();
            chk($sformatf("run_sec%0d", i), int'(sec), i % 60);
        end

        for (int i = 4; i <= 16; i++) apply_row(i);

        // SET_MIN auto-repeat: key held for 30 samples starting at edge n.
        begin
            int n;
            int offs[6];
            offs = '{1, 11, 15, 19, 23, 27};
            n = cyc + 1;
            key_inc = 1'b0;
            foreach (offs[k]) push_strobe(n + offs[k], 1'b0, 1'b0);
            repeat (30) next_cycle();
            key_inc = 1'b1;
            repeat (12) next_cycle();
            chk("repeat_mode_kept", int'(mode), 2);
        end

        for (int i = 17; i <= 18; i++) apply_row(i);

        for (int i = 1; i <= 59; i++) begin
            tick = 1'b1;
            next_cycle();
            tick = 1'b0;
            next_cycle();
        end
        chk("sec_at_59", int'(sec), 59);

        for (int i = 19; i <= 20; i++) apply_row(i);

        // Reset while key_inc is held in SET_HR, with the hr strobe in flight.
        key_inc = 1'b0;
        push_strobe(cyc + 2, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        chk("hr_strobe_before_rst", int'({hr_inc, mode}), int'({1'b1, 2'd1}));
        #1 rst = 1'b0;
        #1 chk("async_reset", pack_outs(), 0);
        next_cycle();
        rst = 1'b1;
        repeat (6) next_cycle();
        chk("post_reset_held_inc", pack_outs(), 0);
        key_mode = 1'b0;
        next_cycle();
        next_cycle();
        chk("post_reset_mode_press", int'(mode), 1);
        key_mode = 1'b1;
        repeat (4) next_cycle();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode and time-set controller for the four-digit HH:MM digital clock. It takes the debounced mode and increment keys plus the 1 Hz tick from the divider. From these it sequences the minute/hour counter datapath with single-cycle increment strobes and drives the blink mask to the LED scan unit. The controller owns the seconds count, the run/set-hour/set-minute state machine and key auto-repeat. Digit wrap (59→00, 23→00) stays in the counter datapath.

## Interface
- HOLD_CYCLES, 5000000: cycles the inc key must stay held before auto-repeat starts.
- REPEAT_CYCLES, 2500000: cycles between auto-repeat strobes.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle strobe, 1 Hz, synchronous to clk.
- key_mode  in  1  debounced mode key, active-low level.
- key_inc  in  1  debounced increment key, active-low level.
- min_inc  out  1  one-cycle strobe: advance minutes by one.
- min_carry_en  out  1  qualifies min_inc: 1 = minute wrap carries into hours, 0 = no carry.
- hr_inc  out  1  one-cycle strobe: advance hours by one.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven.
- blink_mask  out  4  1 = blank digit; bit0 min_low, bit1 min_high, bit2 hr_low, bit3 hr_high.
- sec  out  6  current seconds, 0..59.

## Operation
- All outputs are registered. Reset values: every output is 0 and the state is RUN. Internal key history registers reset to 1 (released), so reset release never produces a press.
- Press definition: a key sampled 0 at an edge where it was sampled 1 at the previous edge.
- State machine: mode presses cycle RUN → SET_HR → SET_MIN → RUN. Leaving any state clears the blink phase to 0 and resets the repeat counter.
- RUN: sec increments on each tick. On a tick with sec==59, sec goes to 0 and the controller pulses min_inc with min_carry_en=1. Inc presses are ignored.
- SET_HR: tick is not counted, so sec holds. An inc press pulses hr_inc with min_carry_en=0.
- SET_MIN: tick is not counted. An inc press pulses min_inc with min_carry_en=0, so minutes wrap without touching hours.
- SET_MIN → RUN transition clears sec to 0. SET_HR → SET_MIN leaves sec unchanged.
- Auto-repeat, set states only: the repeat counter starts at the press.
  - After HOLD_CYCLES cycles of continuous key_inc=0, the controller emits one additional strobe.
  - After that, it emits one strobe every REPEAT_CYCLES cycles while the key stays low.
  - Release (key_inc=1) resets the repeat counter immediately.
  - The counter saturates and never wraps.
- Blink:
  - The blink phase toggles on every tick in the set states.
  - SET_HR: blink_mask = 4'b1100 when phase=1.
  - SET_MIN: blink_mask = 4'b0011 when phase=1.
  - Otherwise blink_mask = 0, including RUN at all times.
  - While key_inc is held in a set state, blink_mask is forced to 0.
- Simultaneous events:
  - Mode press and inc press in the same cycle: the mode press wins and the inc press is discarded. The repeat counter does not start.
  - Mode press and tick in the same cycle: the tick is processed under the current (pre-transition) state. For example, RUN with sec==59 still issues min_inc.
  - Auto-repeat strobe and mode press in the same cycle: the strobe is suppressed.
- min_inc and hr_inc are never both high. At most one strobe is issued per cycle.

## Timing
- Press sampled at edge N → strobe high from edge N+1 to N+2, exactly one cycle.
- Tick sampled at edge N → sec updated at N+1, with min_inc (on rollover) high in the same cycle.
- Mode press sampled at edge N → mode and blink_mask take their new values at N+1.
- First auto-repeat strobe: HOLD_CYCLES cycles after the press strobe. Each later strobe: REPEAT_CYCLES cycles after the previous one.
- Reset asserted mid-operation: outputs go to 0 asynchronously, including any strobe in flight. After release, the first press is counted only from a fresh 1→0 transition.

## Test plan
The bench overrides HOLD_CYCLES=10 and REPEAT_CYCLES=4.
- Reset release with both keys held low → no strobes, mode=00, sec=0. Releasing and re-pressing key_inc in RUN → still no strobe.
- RUN, apply 60 ticks → sec steps 1..59 then 0. Exactly one min_inc with min_carry_en=1, one cycle after the 60th tick sample.
- Mode press ×1 → mode=01. Then inc press → one hr_inc one cycle after the sample. Mode press → mode=10. Then inc press → min_inc with min_carry_en=0. Mode press → mode=00, sec=0.
- SET_MIN, key_inc held 30 cycles → strobes at offsets 1, 11, 15, 19, 23, 27 from the sample. Release → no further strobes.
- SET_HR, 2 ticks with key released → blink_mask goes 1100 then 0000. Holding key_inc → blink_mask=0000 across ticks.
- RUN with sec=59: mode press and tick in the same cycle → min_inc (min_carry_en=1) and mode=01 in the same cycle. Then assert rst while key_inc is held in SET_HR → all outputs 0 immediately.
